// File: rtl/rgb_stream_checker_pkg.sv
// Shared types and helpers for the RGB stream checker: checker states,
// timestamp width and a channel extractor usable for any channel width.
package generic_pack;

    localparam int CHK_TS_W      = 32;
    localparam int CHK_MAX_CH_W  = 32;
    localparam int CHK_MAX_PIX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FAIL = 2'b10
    } chk_state_t;

    // Callers zero-extend their pixel to CHK_MAX_PIX_W; the result is zero-extended too.
    function automatic logic [CHK_MAX_CH_W-1:0] pixel_channel(
        input logic [CHK_MAX_PIX_W-1:0] pix,
        input int                       c,
        input int                       chw
    );
        logic [CHK_MAX_PIX_W-1:0] shifted;
        logic [CHK_MAX_CH_W-1:0]  mask;
        shifted = pix >> (c * chw);
        mask    = (chw >= CHK_MAX_CH_W) ? '1 :
                  ((CHK_MAX_CH_W'(1) << chw) - CHK_MAX_CH_W'(1));
        return shifted[CHK_MAX_CH_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/rgb_stream_checker_fifo.sv
// Synchronous FIFO holding {expected pixel, push timestamp}. When empty and
// pushed/popped in the same cycle, the input is forwarded and nothing is stored.
module rgb_chk_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 56
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_bypass;
    logic             w_wr;
    logic             w_rd;

    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_bypass = i_push & i_pop & o_empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_wr     = i_push & ~w_bypass & (~o_full | i_pop);
    assign w_rd     = i_pop & ~o_empty;
    assign o_dout   = w_bypass ? i_din : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_stream_checker.sv
// Compares the expected pixel stream against the MM2S read-back channel by
// channel and keeps match/mismatch statistics, sticky flags and peak latency.
module rgb_stream_checker
    import generic_pack::*;
#(
    parameter int NUM_CH        = 3,
    parameter int CH_W          = 8,
    parameter int TDATA_W       = 32,
    parameter int DEPTH         = 16,
    parameter int TOL           = 0,
    parameter int COUNT_W       = 32,
    parameter int STOP_ON_ERROR = 0
) (
    input  logic                   pixclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   valid,
    input  logic [NUM_CH*CH_W-1:0] iPixel,
    input  logic                   m_axis_mm2s_tvalid,
    input  logic                   m_axis_mm2s_tready,
    input  logic [TDATA_W-1:0]     m_axis_mm2s_tdata,
    output logic [COUNT_W-1:0]     match_count,
    output logic [COUNT_W-1:0]     mismatch_count,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   error,
    output logic [COUNT_W-1:0]     first_err_index,
    output logic [CHK_TS_W-1:0]    max_latency,
    output logic [1:0]             state
);

    localparam int PIX_W = NUM_CH * CH_W;
    localparam int ENT_W = PIX_W + CHK_TS_W;

    chk_state_t          r_state;
    chk_state_t          w_stateNext;
    logic [CHK_TS_W-1:0] r_ts;
    logic [COUNT_W-1:0]  r_matchCount;
    logic [COUNT_W-1:0]  r_mismatchCount;
    logic [COUNT_W-1:0]  r_firstErr;
    logic [CHK_TS_W-1:0] r_maxLatency;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_error;

    logic                w_clr;
    logic                w_run;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [ENT_W-1:0]    w_fifoOut;
    logic [PIX_W-1:0]    w_expPix;
    logic [CHK_TS_W-1:0] w_latency;
    logic [NUM_CH-1:0]   w_chOk;
    logic                w_match;
    logic                w_cmp;
    logic                w_mismatchEv;
    logic                w_ovfEv;
    logic                w_udfEv;
    logic                w_anyErr;
    logic [COUNT_W:0]    w_sum;
    logic [COUNT_W-1:0]  w_total;

    assign w_clr  = reset | clear;
    assign w_run  = (r_state == RUN);
    assign w_push = valid & w_run;
    assign w_pop  = m_axis_mm2s_tvalid & m_axis_mm2s_tready & w_run;

    rgb_chk_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (pixclk),
        .rst     (w_clr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({iPixel, r_ts}),
        .o_dout  (w_fifoOut),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // On bypass the FIFO forwards the current timestamp, so latency is 0.
    assign w_expPix  = w_fifoOut[ENT_W-1:CHK_TS_W];
    assign w_latency = r_ts - w_fifoOut[CHK_TS_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CHK_MAX_CH_W-1:0] w_expCh;
        logic [CHK_MAX_CH_W-1:0] w_actCh;
        logic [CHK_MAX_CH_W:0]   w_diff;
        assign w_expCh   = pixel_channel(CHK_MAX_PIX_W'(w_expPix), c, CH_W);
        assign w_actCh   = pixel_channel(CHK_MAX_PIX_W'(m_axis_mm2s_tdata), c, CH_W);
        assign w_diff    = (w_expCh >= w_actCh) ? ({1'b0, w_expCh} - {1'b0, w_actCh})
                                                : ({1'b0, w_actCh} - {1'b0, w_expCh});
        assign w_chOk[c] = (w_diff <= (CHK_MAX_CH_W+1)'(TOL));
    end

    assign w_match      = &w_chOk;
    assign w_cmp        = w_pop & (~w_empty | w_push);
    assign w_mismatchEv = w_cmp & ~w_match;
    assign w_ovfEv      = w_push & w_full & ~w_pop;
    assign w_udfEv      = w_pop & w_empty & ~w_push;
    assign w_anyErr     = w_mismatchEv | w_ovfEv | w_udfEv;
    assign w_sum        = {1'b0, r_matchCount} + {1'b0, r_mismatchCount};
    assign w_total      = w_sum[COUNT_W] ? '1 : w_sum[COUNT_W-1:0];

    always_ff @(posedge pixclk) begin
        if (w_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (enable) w_stateNext = RUN;
            RUN: begin
                if ((STOP_ON_ERROR != 0) && w_anyErr) begin
                    w_stateNext = FAIL;
                end else if (!enable) begin
                    w_stateNext = IDLE;
                end
            end
            FAIL:    w_stateNext = FAIL;
            default: w_stateNext = IDLE;
        endcase
    end

    // Statistics are registered at the pop handshake edge; counters saturate.
    always_ff @(posedge pixclk) begin
        if (w_clr) begin
            r_ts            <= '0;
            r_matchCount    <= '0;
            r_mismatchCount <= '0;
            r_firstErr      <= '0;
            r_maxLatency    <= '0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            if (w_run) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_cmp) begin
                if (w_match) begin
                    if (r_matchCount != '1) r_matchCount <= r_matchCount + 1'b1;
                end else begin
                    if (r_mismatchCount != '1) r_mismatchCount <= r_mismatchCount + 1'b1;
                    if (r_mismatchCount == '0) r_firstErr <= w_total;
                end
                if (w_latency > r_maxLatency) begin
                    r_maxLatency <= w_latency;
                end
            end
            if (w_ovfEv) r_overflow  <= 1'b1;
            if (w_udfEv) r_underflow <= 1'b1;
            r_error <= r_error | w_anyErr;
        end
    end

    assign match_count     = r_matchCount;
    assign mismatch_count  = r_mismatchCount;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;
    assign error           = r_error;
    assign first_err_index = r_firstErr;
    assign max_latency     = r_maxLatency;
    assign state           = r_state;

endmodule

// File: tb/tb_rgb_stream_checker.sv
// Directed bench for rgb_stream_checker: three instances (default, TOL=1,
// STOP_ON_ERROR=1) share stimulus; a queue model predicts the default one.
module tb_rgb_stream_checker;

    logic        pixclk = 1'b0;
    logic        reset, enable, clear, valid, tvalid, tready;
    logic [23:0] iPixel;
    logic [31:0] tdata;

    logic [31:0] dMatch, dMis, dFirst, dLat;
    logic        dOvf, dUdf, dErr;
    logic [1:0]  dState;
    logic [31:0] tMatch, tMis, tFirst, tLat;
    logic        tOvf, tUdf, tErr;
    logic [1:0]  tState;
    logic [31:0] sMatch, sMis, sFirst, sLat;
    logic        sOvf, sUdf, sErr;
    logic [1:0]  sState;

    int          checks = 0;
    int          errors = 0;

    logic [23:0] expQ[$];
    int unsigned expMatch, expMis, expFirst;
    logic        expOvf, expUdf;

    always #5 pixclk = ~pixclk;

    rgb_stream_checker dut (
        .pixclk(pixclk), .reset(reset), .enable(enable), .clear(clear), .valid(valid),
        .iPixel(iPixel), .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tready(tready),
        .m_axis_mm2s_tdata(tdata), .match_count(dMatch), .mismatch_count(dMis),
        .overflow(dOvf), .underflow(dUdf), .error(dErr), .first_err_index(dFirst),
        .max_latency(dLat), .state(dState)
    );

    rgb_stream_checker #(.TOL(1)) dutTol (
        .pixclk(pixclk), .reset(reset), .enable(enable), .clear(clear), .valid(valid),
        .iPixel(iPixel), .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tready(tready),
        .m_axis_mm2s_tdata(tdata), .match_count(tMatch), .mismatch_count(tMis),
        .overflow(tOvf), .underflow(tUdf), .error(tErr), .first_err_index(tFirst),
        .max_latency(tLat), .state(tState)
    );

    rgb_stream_checker #(.STOP_ON_ERROR(1)) dutStop (
        .pixclk(pixclk), .reset(reset), .enable(enable), .clear(clear), .valid(valid),
        .iPixel(iPixel), .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tready(tready),
        .m_axis_mm2s_tdata(tdata), .match_count(sMatch), .mismatch_count(sMis),
        .overflow(sOvf), .underflow(sUdf), .error(sErr), .first_err_index(sFirst),
        .max_latency(sLat), .state(sState)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic modelReset();
        expQ.delete();
        expMatch = 0;
        expMis   = 0;
        expFirst = 0;
        expOvf   = 1'b0;
        expUdf   = 1'b0;
    endtask

    // Drives one cycle of push and/or pop and updates the scoreboard for the default instance.
    task automatic applyStimulus(input logic doPush, input logic [23:0] pix,
                                 input logic doPop, input logic [23:0] act);
        logic [23:0] e;
        logic        have;
        logic        bypass;
        valid  = doPush;
        iPixel = pix;
        tvalid = doPop;
        tdata  = {8'hEE, act};
        have   = 1'b0;
        bypass = 1'b0;
        e      = '0;
        if (doPop) begin
            if (expQ.size() > 0) begin
                e    = expQ.pop_front();
                have = 1'b1;
            end else if (doPush) begin
                e      = pix;
                have   = 1'b1;
                bypass = 1'b1;
            end else begin
                expUdf = 1'b1;
            end
            if (have) begin
                if (e == act) begin
                    expMatch++;
                end else begin
                    if (expMis == 0) expFirst = expMatch + expMis;
                    expMis++;
                end
            end
        end
        if (doPush && !bypass) begin
            if (expQ.size() < 16) expQ.push_back(pix);
            else                  expOvf = 1'b1;
        end
        step();
        valid  = 1'b0;
        tvalid = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_match"},    dMatch, expMatch);
        checkOutput({tag, "_mismatch"}, dMis,   expMis);
        checkOutput({tag, "_overflow"}, 32'(dOvf), 32'(expOvf));
        checkOutput({tag, "_underflow"}, 32'(dUdf), 32'(expUdf));
        checkOutput({tag, "_error"},    32'(dErr), 32'((expMis != 0) || expOvf || expUdf));
        checkOutput({tag, "_firsterr"}, dFirst, expFirst);
    endtask

    task automatic doClear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        valid  = 1'b0;
        tvalid = 1'b0;
        tready = 1'b1;
        iPixel = '0;
        tdata  = '0;
        modelReset();
        step();
        step();
        reset = 1'b0;
        step();
        checkModel("reset");
        checkOutput("reset_state", 32'(dState), 32'd0);
        checkOutput("reset_maxlat", dLat, 32'd0);

        enable = 1'b1;
        step();
        checkOutput("enable_run", 32'(dState), 32'd1);

        $display("[TB] three pixels, five cycle latency");
        applyStimulus(1'b1, 24'h102030, 1'b0, 24'h0);
        applyStimulus(1'b1, 24'h405060, 1'b0, 24'h0);
        applyStimulus(1'b1, 24'h708090, 1'b0, 24'h0);
        applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
        applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h102030);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h405060);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h708090);
        checkModel("t1");
        checkOutput("t1_maxlat", dLat, 32'd5);

        $display("[TB] off-by-one pixel, TOL 0 and TOL 1");
        doClear();
        checkModel("clr1");
        checkOutput("clr1_state", 32'(dState), 32'd0);
        step();
        applyStimulus(1'b1, 24'h102030, 1'b0, 24'h0);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h102031);
        checkModel("t2");
        checkOutput("t2_state_run", 32'(dState), 32'd1);
        checkOutput("t2_tol_match", tMatch, 32'd1);
        checkOutput("t2_tol_mismatch", tMis, 32'd0);
        checkOutput("t2_tol_error", 32'(tErr), 32'd0);
        checkOutput("t2_stop_state", 32'(sState), 32'd2);

        $display("[TB] stop on error");
        doClear();
        step();
        applyStimulus(1'b1, 24'h111111, 1'b0, 24'h0);
        applyStimulus(1'b1, 24'h222222, 1'b0, 24'h0);
        applyStimulus(1'b1, 24'h333333, 1'b0, 24'h0);
        applyStimulus(1'b1, 24'h444444, 1'b0, 24'h0);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h111111);
        checkOutput("t3_stop_state_run", 32'(sState), 32'd1);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h22222F);
        checkOutput("t3_stop_state_fail", 32'(sState), 32'd2);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h333333);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h444444);
        checkOutput("t3_stop_match", sMatch, 32'd1);
        checkOutput("t3_stop_mismatch", sMis, 32'd1);
        checkOutput("t3_stop_firsterr", sFirst, 32'd1);
        checkOutput("t3_stop_state_held", 32'(sState), 32'd2);
        checkModel("t3");

        $display("[TB] overflow on the 17th push");
        doClear();
        step();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 24'(i * 32'h010101 + 32'h000100), 1'b0, 24'h0);
            if (i == 15) checkOutput("t4_no_overflow_16", 32'(dOvf), 32'd0);
        end
        checkOutput("t4_overflow_17", 32'(dOvf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 24'h0, 1'b1, 24'(i * 32'h010101 + 32'h000100));
        end
        checkModel("t4");
        checkOutput("t4_maxlat", dLat, 32'd17);

        $display("[TB] empty FIFO: tready low, underflow, bypass");
        doClear();
        step();
        tvalid = 1'b1;
        tready = 1'b0;
        tdata  = 32'h00123456;
        step();
        tvalid = 1'b0;
        tready = 1'b1;
        checkOutput("t5_no_handshake", 32'(dUdf), 32'd0);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h123456);
        checkModel("t5a");
        applyStimulus(1'b1, 24'hAABBCC, 1'b1, 24'hAABBCC);
        checkModel("t5b");
        checkOutput("t5_maxlat", dLat, 32'd0);

        $display("[TB] clear with entries queued");
        doClear();
        step();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 24'(32'h500000 + i), 1'b0, 24'h0);
        end
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h500000);
        checkOutput("t6_maxlat_before", dLat, 32'd6);
        checkOutput("t6_match_before", dMatch, 32'd1);
        doClear();
        checkModel("t6_cleared");
        checkOutput("t6_maxlat_cleared", dLat, 32'd0);
        checkOutput("t6_state_idle", 32'(dState), 32'd0);
        step();
        checkOutput("t6_state_run", 32'(dState), 32'd1);
        applyStimulus(1'b0, 24'h0, 1'b1, 24'h500001);
        checkModel("t6_emptied");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
